// File: rtl/onehot_dispatch.sv
// Binary-index to one-hot request dispatcher with a one-entry pending slot and ack-based completion.
// Optional ACTIVE abort after TIMEOUT cycles without ack when DISPATCH_TIMEOUT_EN is defined.
module onehot_dispatch #(
    parameter  int unsigned SEL_WIDTH = 2,
    parameter  int unsigned TIMEOUT   = 16,
    localparam int unsigned LANES     = 1 << SEL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_WIDTH-1:0] in_sel,
    output logic [LANES-1:0]     req,
    input  logic [LANES-1:0]     ack,
    output logic                 busy,
    output logic                 done,
    output logic [SEL_WIDTH-1:0] done_sel,
    output logic                 timeout
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("onehot_dispatch: TIMEOUT must be >= 1");
    end

    state_t               state_q,    state_d;
    logic                 p_valid_q,  p_valid_d;
    logic [SEL_WIDTH-1:0] p_sel_q,    p_sel_d;
    logic [SEL_WIDTH-1:0] cur_sel_q,  cur_sel_d;
    logic [LANES-1:0]     req_q,      req_d;
    logic                 done_q,     done_d;
    logic [SEL_WIDTH-1:0] done_sel_q, done_sel_d;
    logic                 timeout_q,  timeout_d;
    logic                 accept;

`ifdef DISPATCH_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // in_ready depends only on registered state, never on in_valid or ack
    assign in_ready = !p_valid_q;
    assign accept   = in_valid && !p_valid_q;

    assign req      = req_q;
    assign busy     = (state_q == ACTIVE);
    assign done     = done_q;
    assign done_sel = done_sel_q;
    assign timeout  = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            p_valid_q  <= 1'b0;
            p_sel_q    <= '0;
            cur_sel_q  <= '0;
            req_q      <= '0;
            done_q     <= 1'b0;
            done_sel_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_valid_q  <= p_valid_d;
            p_sel_q    <= p_sel_d;
            cur_sel_q  <= cur_sel_d;
            req_q      <= req_d;
            done_q     <= done_d;
            done_sel_q <= done_sel_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        p_valid_d  = p_valid_q;
        p_sel_d    = p_sel_q;
        cur_sel_d  = cur_sel_q;
        req_d      = req_q;
        done_d     = 1'b0;
        done_sel_d = done_sel_q;
        timeout_d  = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (p_valid_q) begin
                    req_d     = LANES'(1) << p_sel_q;
                    cur_sel_d = p_sel_q;
                    p_valid_d = 1'b0;
                    state_d   = ACTIVE;
`ifdef DISPATCH_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            ACTIVE: begin
                // ack wins over a timeout landing on the same edge
                if (ack[cur_sel_q]) begin
                    req_d      = '0;
                    done_d     = 1'b1;
                    done_sel_d = cur_sel_q;
                    state_d    = IDLE;
                end
`ifdef DISPATCH_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // accept needs an empty slot, launch needs a full one: never on the same edge
        if (accept) begin
            p_valid_d = 1'b1;
            p_sel_d   = in_sel;
        end
    end

endmodule

// File: tb/tb_onehot_dispatch.sv
// Bench for onehot_dispatch: transaction-level model checked every cycle plus directed literal checks.
// Expectations for the abort scenario follow DISPATCH_TIMEOUT_EN.
module tb_onehot_dispatch;

    localparam int unsigned SW = 2;
    localparam int unsigned LN = 4;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_sel;
    logic [LN-1:0] req;
    logic [LN-1:0] ack;
    logic          busy;
    logic          done;
    logic [SW-1:0] done_sel;
    logic          timeout;

    int n_tests = 0;
    int n_fail  = 0;

    onehot_dispatch #(.SEL_WIDTH(SW), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .req      (req),
        .ack      (ack),
        .busy     (busy),
        .done     (done),
        .done_sel (done_sel),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pending queue (depth 1), the lane being requested (-1 = none) and its age.
    int m_pend[$];
    int m_lane = -1;
    int m_age  = 0;
    bit m_done = 1'b0;
    bit m_to   = 1'b0;
    int m_dsel = 0;

    always @(posedge clk or posedge rst) begin
        bit take;
        if (rst) begin
            m_pend.delete();
            m_lane = -1;
            m_age  = 0;
            m_done = 1'b0;
            m_to   = 1'b0;
        end else begin
            take   = in_valid && (m_pend.size() == 0);
            m_done = 1'b0;
            m_to   = 1'b0;
            if (m_lane < 0) begin
                if (m_pend.size() != 0) begin
                    m_lane = m_pend.pop_front();
                    m_age  = 0;
                end
            end else if (ack[m_lane]) begin
                m_done = 1'b1;
                m_dsel = m_lane;
                m_lane = -1;
            end
`ifdef DISPATCH_TIMEOUT_EN
            else if (m_age == TO - 1) begin
                m_to   = 1'b1;
                m_lane = -1;
            end
`endif
            else begin
                m_age++;
            end
            if (take) m_pend.push_back(int'(in_sel));
        end
    end

    always @(negedge clk) begin
        logic [LN-1:0] ereq;
        ereq = (m_lane >= 0) ? (LN'(1) << m_lane) : '0;
        chk("m_req", 32'(req), 32'(ereq));
        chk("m_in_ready", 32'(in_ready), 32'(m_pend.size() == 0));
        chk("m_busy", 32'(busy), 32'(m_lane >= 0));
        chk("m_done", 32'(done), 32'(m_done));
        chk("m_timeout", 32'(timeout), 32'(m_to));
        if (m_done) chk("m_done_sel", 32'(done_sel), 32'(m_dsel));
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, tp, dp;
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; ack = '0;
        #2;
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        tick(2);
        rst = 1'b0;
        tick();

        // Single dispatch to lane 2
        in_valid = 1'b1; in_sel = 2'd2;
        tick();
        in_valid = 1'b0;
        chk("t2_ready_after_accept", 32'(in_ready), 32'h0);
        chk("t2_req_not_yet", 32'(req), 32'h0);
        tick();
        chk("t2_req", 32'(req), 32'b0100);
        chk("t2_busy", 32'(busy), 32'h1);
        tick(2);
        ack = 4'b0100;
        tick();
        chk("t2_req_clr", 32'(req), 32'h0);
        chk("t2_done", 32'(done), 32'h1);
        chk("t2_done_sel", 32'(done_sel), 32'd2);
        ack = '0;
        tick();
        chk("t2_done_pulse", 32'(done), 32'h0);

        // Foreign acks ignored
        in_valid = 1'b1; in_sel = 2'd2;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            ack = (i % 2 != 0) ? 4'b1000 : 4'b0001;
            tick();
            chk("t3_req_hold", 32'(req), 32'b0100);
            chk("t3_no_done", 32'(done), 32'h0);
        end
        ack = 4'b0100;
        tick();
        chk("t3_done", 32'(done), 32'h1);
        chk("t3_done_sel", 32'(done_sel), 32'd2);
        ack = '0;
        tick();

        // Pending command queued behind an active one
        in_valid = 1'b1; in_sel = 2'd3;
        tick();
        in_sel = 2'd0;
        chk("t4_ready0", 32'(in_ready), 32'h0);
        tick();
        chk("t4_req3", 32'(req), 32'b1000);
        chk("t4_ready1", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("t4_ready_full", 32'(in_ready), 32'h0);
        chk("t4_req3_hold", 32'(req), 32'b1000);
        ack = 4'b1000;
        tick();
        ack = '0;
        chk("t4_gap_req", 32'(req), 32'h0);
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_done_sel", 32'(done_sel), 32'd3);
        chk("t4_ready_still_full", 32'(in_ready), 32'h0);
        tick();
        chk("t4_req0", 32'(req), 32'b0001);
        chk("t4_ready_free", 32'(in_ready), 32'h1);
        ack = 4'b0001;
        tick();
        chk("t4_done0", 32'(done), 32'h1);
        chk("t4_done_sel0", 32'(done_sel), 32'd0);
        ack = '0;
        tick();

        // Same lane repeatedly with ack held high through the gaps
        in_valid = 1'b1; in_sel = 2'd1; ack = 4'b0010;
        tick(8);
        in_valid = 1'b0;
        tick(6);
        ack = '0;
        tick(2);

        // Reset while active with a pending command
        in_valid = 1'b1; in_sel = 2'd3;
        tick();
        in_sel = 2'd1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("t5_ready_full", 32'(in_ready), 32'h0);
        chk("t5_req3", 32'(req), 32'b1000);
        #3 rst = 1'b1;
        #1;
        chk("t5_req_async", 32'(req), 32'h0);
        chk("t5_ready_async", 32'(in_ready), 32'h1);
        chk("t5_busy_async", 32'(busy), 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_req", 32'(req), 32'h0);
            chk("t5_no_done", 32'(done), 32'h0);
        end

        // No ack: abort after TO active cycles, or wait indefinitely
        hi = 0; tp = 0; dp = 0;
        in_valid = 1'b1; in_sel = 2'd0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (req == 4'b0001) hi++;
            tp += int'(timeout);
            dp += int'(done);
            tick();
        end
`ifdef DISPATCH_TIMEOUT_EN
        chk("t6_active_cycles", 32'(hi), 32'd8);
        chk("t6_timeout_pulses", 32'(tp), 32'd1);
`else
        chk("t6_active_cycles", 32'(hi), 32'd24);
        chk("t6_timeout_pulses", 32'(tp), 32'd0);
`endif
        chk("t6_done_pulses", 32'(dp), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
